add_accum_28: RTL and testbench

ADD_ACCUM_28 -- requirements
Module: add_accum_28

---
 rtl/add_accum_28.sv | 138 +++++++++++++
 tb/tb_add_accum_28.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accum_28.sv
// Frame accumulator: sums unsigned beats of a valid/ready frame and presents the
// modulo sum, sticky carry flag and saturating beat count until downstream takes it.

module adder #(
    parameter int unsigned WIDTH = 28
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

module add_accum_28 #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_sat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cnt_sat_q, cnt_sat_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Gated by rst_n so the upstream never sees ready while the block is held in reset.
    assign in_ready = rst_n && (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        cnt_sat_d = cnt_sat_q;

        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    if (count_q == CNT_MAX) begin
                        cnt_sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                // Clearing here leaves IDLE with a zero accumulator, so the next frame
                // starts clean without a separate init step.
                if (out_ready) begin
                    state_d   = IDLE;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    count_d   = '0;
                    cnt_sat_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                acc_d     = '0;
                ovf_d     = 1'b0;
                count_d   = '0;
                cnt_sat_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            cnt_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            cnt_sat_q <= cnt_sat_d;
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign out_sum     = acc_q;
    assign out_ovf     = ovf_q;
    assign out_count   = count_q;
    assign out_cnt_sat = cnt_sat_q;

endmodule

// File: tb/tb_add_accum_28.sv
// Directed table frames, corner-case sequences and a randomized scoreboard run
// for the frame accumulator.

module tb_add_accum_28;

    localparam int unsigned WIDTH = 28;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;
    logic             out_cnt_sat;

    int total = 0;
    int bad = 0;

    add_accum_28 #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf),
        .out_count  (out_count),
        .out_cnt_sat(out_cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  n;
        logic [3:0][27:0]    d;
        logic [WIDTH-1:0]    sum;
        logic                ovf;
        logic [CNT_W-1:0]    cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic send_beat(input logic [27:0] d, input logic last, input bit rnd);
        bit ok;
        ok = 1'b0;
        if (rnd) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 50; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            step();
            if (ok) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    // Waits for the result handshake, checking outputs stay frozen while stalled.
    task automatic get_result(input bit rnd, output logic [27:0] s, output logic o,
                              output logic [7:0] c, output logic sat);
        bit got, held;
        logic [27:0] hs;
        logic        ho, hsat;
        logic [7:0]  hc;
        got = 1'b0;
        held = 1'b0;
        s = '0; o = 1'b0; c = '0; sat = 1'b0;
        hs = '0; ho = 1'b0; hc = '0; hsat = 1'b0;
        for (int k = 0; k < 100; k++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid) chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && held) begin
                chk("stall_sum", 32'(out_sum), 32'(hs));
                chk("stall_ovf", 32'(out_ovf), 32'(ho));
                chk("stall_count", 32'(out_count), 32'(hc));
                chk("stall_sat", 32'(out_cnt_sat), 32'(hsat));
            end
            if (out_valid && !out_ready) begin
                held = 1'b1;
                hs = out_sum; ho = out_ovf; hc = out_count; hsat = out_cnt_sat;
            end
            if (out_valid && out_ready) begin
                s = out_sum; o = out_ovf; c = out_count; sat = out_cnt_sat;
                got = 1'b1;
            end
            step();
            if (got) break;
        end
        out_ready = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got no out_valid handshake expected one within 100 cycles");
        end
    endtask

    initial begin
        logic [27:0] rs;
        logic        ro, rsat;
        logic [7:0]  rc;
        logic [28:0] m_sum;
        logic        m_ovf;
        int          m_cnt;
        int          n;
        logic [27:0] d;

        tbl[0] = '{3, {28'h0, 28'h000000A, 28'h0000007, 28'h0000005}, 28'h0000016, 1'b0, 8'd3};
        tbl[1] = '{2, {28'h0, 28'h0, 28'h0000002, 28'hFFFFFFF}, 28'h0000001, 1'b1, 8'd2};
        tbl[2] = '{1, {28'h0, 28'h0, 28'h0, 28'h0000001}, 28'h0000001, 1'b0, 8'd1};
        tbl[3] = '{1, {28'h0, 28'h0, 28'h0, 28'hABCDEF0}, 28'hABCDEF0, 1'b0, 8'd1};
        tbl[4] = '{4, {28'h8000000, 28'h8000000, 28'h8000000, 28'h8000000},
                   28'h0000000, 1'b1, 8'd4};
        tbl[5] = '{1, {28'h0, 28'h0, 28'h0, 28'h0000000}, 28'h0000000, 1'b0, 8'd1};
        tbl[6] = '{2, {28'h0, 28'h0, 28'h0EDCBA9, 28'h1234567}, 28'h2111110, 1'b0, 8'd2};

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_flags", {30'd0, out_ovf, out_cnt_sat}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        // Directed frames
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < tbl[v].n; b++) send_beat(tbl[v].d[b], b == tbl[v].n - 1, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_sum", v), 32'(out_sum), 32'(tbl[v].sum));
            chk($sformatf("v%0d_ovf", v), 32'(out_ovf), 32'(tbl[v].ovf));
            chk($sformatf("v%0d_count", v), 32'(out_count), 32'(tbl[v].cnt));
            chk($sformatf("v%0d_sat", v), 32'(out_cnt_sat), 32'd0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_idle_valid", v), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_idle_count", v), 32'(out_count), 32'd0);
            chk($sformatf("v%0d_idle_ready", v), 32'(in_ready), 32'd1);
            step();
        end

        // Backpressure with a beat waiting upstream
        out_ready = 1'b0;
        send_beat(28'h0000100, 1'b0, 1'b0);
        send_beat(28'h0000023, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 28'h0000055;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'h123);
            chk("bp_count", 32'(out_count), 32'd2);
            chk("bp_ovf", 32'(out_ovf), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_handoff_valid", 32'(out_valid), 32'd0);
        chk("bp_handoff_ready", 32'(in_ready), 32'd1);
        chk("bp_handoff_sum", 32'(out_sum), 32'd0);
        step();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_sum", 32'(out_sum), 32'h55);
        chk("bp_next_count", 32'(out_count), 32'd1);
        step();
        step();

        // Count saturation
        for (int i = 0; i < 257; i++) send_beat(28'h0000001, i == 256, 1'b0);
        @(negedge clk);
        chk("sat_valid", 32'(out_valid), 32'd1);
        chk("sat_count", 32'(out_count), 32'd255);
        chk("sat_flag", 32'(out_cnt_sat), 32'd1);
        chk("sat_sum", 32'(out_sum), 32'h101);
        chk("sat_ovf", 32'(out_ovf), 32'd0);
        step();
        @(negedge clk);
        chk("sat_cleared", 32'(out_cnt_sat), 32'd0);
        step();

        // Reset mid-frame after 2 of 4 beats
        send_beat(28'h0000003, 1'b0, 1'b0);
        send_beat(28'h0000004, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
            chk("mid_rst_zero", {3'd0, out_ovf, out_cnt_sat, out_count, out_sum[18:0]}, 32'd0);
            step();
        end
        send_beat(28'h0000009, 1'b1, 1'b0);
        @(negedge clk);
        chk("fresh_sum", 32'(out_sum), 32'h9);
        chk("fresh_count", 32'(out_count), 32'd1);
        chk("fresh_valid", 32'(out_valid), 32'd1);
        step();
        step();

        // Reset while holding a result
        out_ready = 1'b0;
        send_beat(28'h0000007, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_rst_no_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Random gaps and backpressure against a scoreboard model
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(1, 6);
            m_sum = '0;
            m_ovf = 1'b0;
            m_cnt = 0;
            for (int b = 0; b < n; b++) begin
                d = 28'($urandom);
                if ($urandom_range(0, 3) == 0) d = 28'($urandom_range(0, 15));
                m_sum = {1'b0, m_sum[27:0]} + {1'b0, d};
                m_ovf = m_ovf | m_sum[28];
                m_cnt++;
                send_beat(d, b == n - 1, 1'b1);
            end
            get_result(1'b1, rs, ro, rc, rsat);
            chk($sformatf("rnd%0d_sum", f), 32'(rs), 32'(m_sum[27:0]));
            chk($sformatf("rnd%0d_ovf", f), 32'(ro), 32'(m_ovf));
            chk($sformatf("rnd%0d_count", f), 32'(rc), 32'(m_cnt));
            chk($sformatf("rnd%0d_sat", f), 32'(rsat), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
